// File: rtl/onchip_mem_stream_master_if.sv
// Command, Avalon-MM master and word-stream signals of the
// on-chip memory stream master.
interface onchip_mem_stream_master_if #(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 14
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              busy;
  logic              done;
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [31:0]       snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic [31:0]       src_data;
  logic              src_valid;
  logic              src_ready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  avm_waitrequest, avm_readdata,
    input  avm_readdatavalid,
    input  snk_data, snk_valid, src_ready,
    output cmd_ready, busy, done,
    output avm_address, avm_read, avm_write,
    output avm_writedata, avm_byteenable,
    output snk_ready, src_data, src_valid
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output avm_waitrequest, avm_readdata,
    output avm_readdatavalid,
    output snk_data, snk_valid, src_ready,
    input  cmd_ready, busy, done,
    input  avm_address, avm_read, avm_write,
    input  avm_writedata, avm_byteenable,
    input  snk_ready, src_data, src_valid
  );
endinterface

// File: rtl/onchip_mem_stream_master.sv
// Avalon-MM master moving words between a valid/ready stream
// and the on-chip memory, with a credit-limited read FIFO.
module onchip_mem_stream_master #(
  parameter int ADDR_W  = 13,
  parameter int LEN_W   = 14,
  parameter int MAX_OUT = 4
) (
  input logic clk,
  input logic reset_n,
  onchip_mem_stream_master_if.master bus
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {
    IDLE, WRITE, READ, DRAIN
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] bus_addr;
  logic [ADDR_W-1:0] load_addr;
  logic [LEN_W-1:0]  rem_q;
  logic [CW-1:0]     outst_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [31:0]       fifo [MAX_OUT];
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic              done_q;
  logic              done_nx;
  logic [SW-1:0]     inflight;

  logic accept, snk_fire, wr_fire, rd_fire;
  logic push, pop, credit, last;

  assign accept   = bus.cmd_valid & bus.cmd_ready;
  assign snk_fire = bus.snk_valid & bus.snk_ready;
  assign wr_fire  = wr_q & ~bus.avm_waitrequest;
  assign rd_fire  = bus.avm_read & ~bus.avm_waitrequest;
  // stray readdatavalid with nothing outstanding is dropped
  assign push     = bus.avm_readdatavalid
                  & (outst_q != '0);
  assign pop      = bus.src_valid & bus.src_ready;
  assign last     = rem_q == LEN_W'(1);
  assign inflight = SW'(outst_q) + SW'(cnt_q);
  assign credit   = inflight < SW'(MAX_OUT);

  // done_q gates cmd_ready so completion and acceptance never overlap
  assign bus.cmd_ready      = (state == IDLE) & ~done_q;
  assign bus.busy           = state != IDLE;
  assign bus.done           = done_q;
  assign bus.avm_address    = {bus_addr, 2'b00};
  assign bus.avm_write      = wr_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.avm_byteenable = 4'hF;
  assign bus.avm_read       = (state == READ)
                            & (rem_q != '0) & credit;
  assign bus.snk_ready      = (state == WRITE)
                            & (~wr_q
                            | (~bus.avm_waitrequest & ~last));
  assign bus.src_valid      = cnt_q != '0;
  assign bus.src_data       = bus.src_valid
                            ? fifo[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_len == '0) begin
            done_nx = 1'b1;
          end else if (bus.cmd_write) begin
            state_nx = WRITE;
          end else begin
            state_nx = READ;
          end
        end
      end
      WRITE: begin
        if (wr_fire && last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      READ: begin
        if (rd_fire && last) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (outst_q == '0 && cnt_q == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      bus_addr  <= '0;
      load_addr <= '0;
      rem_q     <= '0;
      outst_q   <= '0;
      cnt_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      done_q <= done_nx;
      if (accept) begin
        bus_addr  <= bus.cmd_addr;
        load_addr <= bus.cmd_addr;
        rem_q     <= bus.cmd_len;
      end
      if (wr_fire) begin
        wr_q  <= 1'b0;
        rem_q <= rem_q - LEN_W'(1);
      end
      if (snk_fire) begin
        wr_q      <= 1'b1;
        wdata_q   <= bus.snk_data;
        bus_addr  <= load_addr;
        load_addr <= load_addr + ADDR_W'(1);
      end
      if (rd_fire) begin
        rem_q    <= rem_q - LEN_W'(1);
        bus_addr <= bus_addr + ADDR_W'(1);
      end
      outst_q <= outst_q + CW'(rd_fire) - CW'(push);
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.avm_readdata;
  end
endmodule

// File: tb/tb_onchip_mem_stream_master.sv
// Bench for onchip_mem_stream_master: slave memory model,
// write/read scoreboards, vector table and corner sequences.
module tb_onchip_mem_stream_master;
  localparam int ADDR_W  = 13;
  localparam int LEN_W   = 14;
  localparam int MAX_OUT = 4;
  localparam int WORDS   = 1 << ADDR_W;

  typedef struct {
    bit          wr;
    int          addr;
    int          len;
    int          lat;
    bit          stall;
    bit          gappy;
    bit          seq;
    int          exp_bus;
    logic [31:0] exp_baddr;
  } vec_t;
  typedef struct { int addr; int due; } rd_t;
  typedef struct {
    logic [14:0] baddr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] smem [int];
  logic [31:0] ref_mem [int];
  wr_t         wq [$];
  logic [31:0] rq [$];
  rd_t         pend [$];
  logic [31:0] xfer_log [$];

  int rd_lat = 1;
  bit stall_en = 1'b0;
  int src_mode = 1;
  int n_wr = 0, n_rd = 0;
  int done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
  bit ws_prev = 1'b0, rs_prev = 1'b0;
  logic [46:0] w_prev = '0;
  logic [14:0] r_prev = '0;

  onchip_mem_stream_master_if #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) bus ();

  onchip_mem_stream_master #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  function automatic logic [127:0] outs();
    return {bus.cmd_ready, bus.busy, bus.done,
            bus.avm_read, bus.avm_write,
            bus.avm_address, bus.avm_writedata,
            bus.snk_ready, bus.src_valid, bus.src_data};
  endfunction

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // slave model, stream sink and monitors
  always @(negedge clk) begin
    rd_t p;
    wr_t e;
    cyc++;
    bus.avm_waitrequest = stall_en
      ? 1'($urandom_range(0, 1)) : 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata = smem.exists(p.addr)
        ? smem[p.addr] : pat(p.addr);
    end else begin
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata = '0;
    end
    bus.src_ready = (src_mode == 2)
      ? ($urandom_range(0, 2) != 0) : (src_mode == 1);
    #1;
    if (!reset_n) begin
      ws_prev = 1'b0;
      rs_prev = 1'b0;
    end else begin
      if (ws_prev)
        check("wr_hold", {bus.avm_write, bus.avm_address,
              bus.avm_writedata}, {1'b1, w_prev});
      if (rs_prev)
        check("rd_hold", {bus.avm_read, bus.avm_address},
              {1'b1, r_prev});
      ws_prev = bus.avm_write & bus.avm_waitrequest;
      rs_prev = bus.avm_read & bus.avm_waitrequest;
      w_prev = {bus.avm_address, bus.avm_writedata};
      r_prev = bus.avm_address;
      if (bus.avm_write && !bus.avm_waitrequest) begin
        n_wr++;
        last_wr_cyc = cyc;
        xfer_log.push_back(32'(bus.avm_address));
        check("wr_pending", wq.size() > 0, 1'b1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          check("wr_addr", bus.avm_address, e.baddr);
          check("wr_data", bus.avm_writedata, e.data);
        end
        smem[int'(bus.avm_address[14:2])] =
          bus.avm_writedata;
      end
      if (bus.avm_read && !bus.avm_waitrequest) begin
        n_rd++;
        xfer_log.push_back(32'(bus.avm_address));
        pend.push_back('{addr: int'(bus.avm_address[14:2]),
                         due: cyc + rd_lat});
        check("rd_outstanding", pend.size() <= MAX_OUT,
              1'b1);
      end
      if (bus.src_valid && bus.src_ready) begin
        check("src_pending", rq.size() > 0, 1'b1);
        if (rq.size() > 0)
          check("src_data", bus.src_data, rq.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic issue(input bit wr, input int addr,
                       input int len);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr = ADDR_W'(addr);
    bus.cmd_len = LEN_W'(len);
    #1;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("cmd_accept", bus.cmd_ready, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input int addr, input int len,
                      input bit gappy, input bit seq);
    int i = 0;
    int t = 0;
    logic [31:0] w;
    w = seq ? 32'h11 : $urandom;
    while (i < len && t < 4000) begin
      bus.snk_valid = gappy
        ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.snk_data = w;
      #1;
      if (bus.snk_valid && bus.snk_ready) begin
        wq.push_back('{baddr: 15'(((addr + i) % WORDS) * 4),
                       data: w});
        ref_mem[(addr + i) % WORDS] = w;
        i++;
        w = seq ? 32'(32'h11 * (i + 1)) : $urandom;
      end
      @(negedge clk);
      t++;
    end
    bus.snk_valid = 1'b0;
    check("feed_words", i, len);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("done_seen", done_cnt - d0, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int d0, b0, x0;
    rd_lat = v.lat;
    stall_en = v.stall;
    src_mode = v.stall ? 2 : 1;
    if (!v.wr)
      for (int i = 0; i < v.len; i++)
        rq.push_back(ref_rd((v.addr + i) % WORDS));
    d0 = done_cnt;
    b0 = n_wr + n_rd;
    x0 = xfer_log.size();
    @(negedge clk);
    issue(v.wr, v.addr, v.len);
    if (v.wr) feed(v.addr, v.len, v.gappy, v.seq);
    wait_done(d0);
    check($sformatf("v%0d_bus_cycles", idx),
          n_wr + n_rd - b0, v.exp_bus);
    check($sformatf("v%0d_first_baddr", idx),
          (xfer_log.size() > x0) ? xfer_log[x0] : 32'hDEAD,
          v.exp_baddr);
    check($sformatf("v%0d_queues_empty", idx),
          wq.size() + rq.size(), 0);
    if (v.wr)
      check($sformatf("v%0d_done_latency", idx),
            done_cyc - last_wr_cyc, 1);
    stall_en = 1'b0;
    src_mode = 1;
  endtask

  initial begin
    vec_t vecs [8];
    int d0, b0, t;
    logic [127:0] rst_exp;
    rst_exp = {42'd0, 1'b1, 85'd0};
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    bus.snk_valid = 1'b0;
    bus.snk_data = '0;
    // wr addr len lat stall gappy seq exp_bus exp_baddr
    vecs[0] = '{1'b1, 0, 4, 1, 1'b0, 1'b0, 1'b1,
                4, 32'h0000};
    vecs[1] = '{1'b0, 0, 4, 1, 1'b0, 1'b0, 1'b0,
                4, 32'h0000};
    vecs[2] = '{1'b1, 100, 20, 1, 1'b1, 1'b1, 1'b0,
                20, 32'h0190};
    vecs[3] = '{1'b0, 100, 20, 3, 1'b1, 1'b0, 1'b0,
                20, 32'h0190};
    vecs[4] = '{1'b1, 8190, 4, 1, 1'b0, 1'b0, 1'b0,
                4, 32'h7FF8};
    vecs[5] = '{1'b0, 8190, 4, 2, 1'b0, 1'b0, 1'b0,
                4, 32'h7FF8};
    vecs[6] = '{1'b1, 8191, 1, 1, 1'b1, 1'b1, 1'b0,
                1, 32'h7FFC};
    vecs[7] = '{1'b0, 4, 1, 1, 1'b0, 1'b0, 1'b0,
                1, 32'h0010};

    repeat (3) @(negedge clk);
    #2;
    check("reset_outs", outs(), rst_exp);
    reset_n = 1'b1;
    @(negedge clk);
    #2;
    check("idle_outs", outs(), rst_exp);

    for (int v = 0; v < 8; v++) begin
      run_vec(vecs[v], v);
      if (v == 0)
        for (int i = 0; i < 4; i++)
          check($sformatf("mem_word%0d", i),
                smem.exists(i) ? smem[i] : 32'hDEAD,
                32'(32'h11 * (i + 1)));
    end

    // credit limit with a stalled source
    rd_lat = 1;
    src_mode = 0;
    for (int i = 0; i < 16; i++) rq.push_back(ref_rd(i));
    d0 = done_cnt;
    b0 = n_rd;
    @(negedge clk);
    issue(1'b0, 0, 16);
    repeat (20) @(negedge clk);
    #2;
    check("credit_reads", n_rd - b0, MAX_OUT);
    check("credit_read_low", bus.avm_read, 1'b0);
    check("credit_src_valid", bus.src_valid, 1'b1);
    src_mode = 1;
    wait_done(d0);
    check("credit_reads_total", n_rd - b0, 16);
    check("credit_delivered", rq.size(), 0);

    // zero-length command
    d0 = done_cnt;
    b0 = n_wr + n_rd;
    @(negedge clk);
    issue(1'b1, 7, 0);
    #2;
    check("len0_done", bus.done, 1'b1);
    check("len0_cmd_ready", bus.cmd_ready, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    check("len0_no_bus", n_wr + n_rd - b0, 0);
    check("len0_done_once", done_cnt - d0, 1);
    check("len0_ready_again", bus.cmd_ready, 1'b1);

    // reset with two reads in flight
    rd_lat = 4;
    src_mode = 0;
    b0 = n_rd;
    @(negedge clk);
    issue(1'b0, 0, 8);
    t = 0;
    while (n_rd - b0 < 2 && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("rst_two_issued", n_rd - b0, 2);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_outs", outs(), rst_exp);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    src_mode = 1;
    t = 0;
    while (pend.size() > 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    #2;
    check("rst_stale_dropped", {bus.src_valid, bus.busy},
          2'b00);
    run_vec('{1'b0, 0, 4, 1, 1'b0, 1'b0, 1'b0,
              4, 32'h0000}, 90);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
